// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin share of one ALU datapath between two requesters
// Ports: clk/rst (async, active-low); req0_*/req1_* operation valid/ready + func/a/b;
//        rsp0_*/rsp1_* result valid/ready + {f, overflow, cout, sum}; alu_func/alu_a/alu_b
//        to the ALU, alu_res back; gnt_cnt0/gnt_cnt1 grant counters.
// Macro ALU_SHARE_ARB_STATS_EN: saturating grant counters (otherwise tied to 0).
module alu_share_arb #(
  parameter int W = 4,
  parameter int ALU_LAT = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_func,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_func,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [2*W+1:0]   rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [2*W+1:0]   rsp1_data,
  output logic [2:0]       alu_func,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [2*W+1:0]   alu_res,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t     state_q;
  logic       last_q, owner_q, gnt1;
  logic [3:0] wait_q;
  // requester 1 wins when alone or when requester 0 was served last
  assign gnt1 = req1_valid && (!req0_valid || !last_q);
  // gated by rst so no ready is shown while reset is held
  assign req1_ready = rst && state_q == IDLE && gnt1;
  assign req0_ready = rst && state_q == IDLE && req0_valid && !gnt1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      wait_q     <= '0;
      alu_func   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req0_ready || req1_ready) begin
          alu_func <= req1_ready ? req1_func : req0_func;
          alu_a    <= req1_ready ? req1_a : req0_a;
          alu_b    <= req1_ready ? req1_b : req0_b;
          owner_q  <= req1_ready;
          last_q   <= req1_ready;
          wait_q   <= 4'(ALU_LAT);
          state_q  <= WAIT;
        end
        WAIT: if (wait_q == 4'd1) begin
          if (owner_q) begin
            rsp1_data  <= alu_res;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_data  <= alu_res;
            rsp0_valid <= 1'b1;
          end
          state_q <= RESP;
        end else begin
          wait_q <= wait_q - 4'd1;
        end
        RESP: if (owner_q ? rsp1_ready : rsp0_ready) begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (req1_ready && !(&gnt_cnt1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed + random transaction checks of alu_share_arb against a reference model
module tb_alu_share_arb;
  localparam int W = 4, L = 2, CW = 2;
  logic clk = 0, rst = 0;
  logic req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
  logic [2:0] req0_func = 0, req1_func = 0, alu_func;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, alu_a, alu_b;
  logic rsp0_valid, rsp0_ready = 0, rsp1_valid, rsp1_ready = 0;
  logic [2*W+1:0] rsp0_data, rsp1_data, alu_res;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
  int total = 0, bad = 0, ec0 = 0, ec1 = 0;
  bit last = 1;
  logic [9:0] ed0 = 0, ed1 = 0, last_rsp;
  bit gseq[$];

  alu_share_arb #(.W(W), .ALU_LAT(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1));

  always #5 clk = ~clk;

  function automatic logic [9:0] alu_model(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic ov;
    s = (f == 3'd1) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    ov = (f == 3'd1) ? (a[3] != b[3] && s[3] != a[3]) : (a[3] == b[3] && s[3] != a[3]);
    case (f)
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = {3'b0, $signed(a) < $signed(b)};
      3'd7: r = {3'b0, a == b};
      default: r = 4'd0;
    endcase
    return {r, ov, s[4], s[3:0]};
  endfunction

  assign alu_res = alu_model(alu_func, alu_a, alu_b);

  function automatic int expc(input int c);
`ifdef ALU_SHARE_ARB_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req0_valid = 1'($urandom); req1_valid = 1'($urandom);
    req0_func = 3'($urandom); req1_func = 3'($urandom);
    req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_a = 4'($urandom); req1_b = 4'($urandom);
  endtask

  task automatic model_reset();
    last = 1; ec0 = 0; ec1 = 0; ed0 = 0; ed1 = 0;
  endtask

  task automatic reset_dut();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    rst = 0;
    model_reset();
    tick();
    tick();
    rst = 1;
  endtask

  task automatic op(input bit v0, input bit v1, input logic [2:0] f0, input logic [2:0] f1,
                    input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] a1, input logic [3:0] b1,
                    input int stall);
    bit g;
    logic [2:0] ef;
    logic [3:0] ea, eb;
    logic [9:0] ed;
    req0_valid = v0; req1_valid = v1; req0_func = f0; req1_func = f1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    if (!v0 && !v1) begin
      chk("idle_rdy0", req0_ready, 0);
      chk("idle_rdy1", req1_ready, 0);
      tick();
      return;
    end
    g = (v0 && v1) ? !last : v1;
    chk("gnt_rdy0", req0_ready, !g);
    chk("gnt_rdy1", req1_ready, g);
    gseq.push_back(req1_ready);
    {ef, ea, eb} = g ? {f1, a1, b1} : {f0, a0, b0};
    ed = alu_model(ef, ea, eb);
    tick();
    last = g;
    if (g) ec1 = (ec1 < 3) ? ec1 + 1 : 3;
    else ec0 = (ec0 < 3) ? ec0 + 1 : 3;
    chk("cnt0", gnt_cnt0, expc(ec0));
    chk("cnt1", gnt_cnt1, expc(ec1));
    for (int i = 0; i < L; i++) begin
      scramble();
      rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
      #1;
      chk("wait_rdy", {req0_ready, req1_ready}, 0);
      chk("wait_func", alu_func, ef);
      chk("wait_a", alu_a, ea);
      chk("wait_b", alu_b, eb);
      chk("wait_valid", {rsp0_valid, rsp1_valid}, 0);
      tick();
    end
    if (g) ed1 = ed; else ed0 = ed;
    for (int s = 0; s <= stall; s++) begin
      scramble();
      rsp0_ready = g ? 1'($urandom) : 1'(s == stall);
      rsp1_ready = g ? 1'(s == stall) : 1'($urandom);
      #1;
      chk("rsp_valid0", rsp0_valid, !g);
      chk("rsp_valid1", rsp1_valid, g);
      chk("rsp_data0", rsp0_data, ed0);
      chk("rsp_data1", rsp1_data, ed1);
      chk("rsp_rdy", {req0_ready, req1_ready}, 0);
      chk("rsp_alu_a", alu_a, ea);
      last_rsp = g ? rsp1_data : rsp0_data;
      tick();
    end
    rsp0_ready = 0; rsp1_ready = 0; req0_valid = 0; req1_valid = 0;
    #1;
    chk("done_valid", {rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    // reset held with requester 0 asking
    req0_valid = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_rdy", {req0_ready, req1_ready}, 0);
      chk("rst_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_data", {rsp0_data, rsp1_data}, 0);
      chk("rst_alu", {alu_func, alu_a, alu_b}, 0);
      chk("rst_cnt", {gnt_cnt0, gnt_cnt1}, 0);
      tick();
    end
    rst = 1;
    #1;
    chk("rel_rdy0", req0_ready, 1);
    chk("rel_rdy1", req1_ready, 0);
    // single add
    op(1, 0, 3'd0, 3'd0, 4'd3, 4'd5, 4'd0, 4'd0, 0);
    chk("add_data", last_rsp, 10'h028);
    // contention from reset
    reset_dut();
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      op(1, 1, 3'd0, 3'd1, 4'd3, 4'd5, 4'd2, 4'd7, 0);
      if (i == 1) chk("sub_rsp1", last_rsp, 10'h01B);
    end
    chk("order_n", gseq.size(), 4);
    for (int i = 0; i < gseq.size(); i++) chk("order", gseq[i], i % 2);
    // response backpressure
    op(1, 1, 3'd5, 3'd3, 4'd9, 4'd6, 4'd12, 4'd10, 5);
    op(1, 1, 3'd6, 3'd7, 4'd8, 4'd1, 4'd4, 4'd4, 3);
    // reset in WAIT
    req0_valid = 1; req1_valid = 0; req0_func = 3'd0; req0_a = 4'd7; req0_b = 4'd1;
    tick();
    tick();
    rst = 0;
    model_reset();
    #1;
    chk("mid_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("mid_alu", {alu_func, alu_a, alu_b}, 0);
    chk("mid_rdy", {req0_ready, req1_ready}, 0);
    chk("mid_cnt", {gnt_cnt0, gnt_cnt1}, 0);
    for (int i = 0; i < L + 2; i++) begin
      tick();
      chk("mid_hold", {rsp0_valid, rsp1_valid}, 0);
    end
    rst = 1;
    op(0, 1, 3'd0, 3'd1, 4'd0, 4'd0, 4'd4, 4'd9, 1);
    // stats saturation
    reset_dut();
    for (int i = 0; i < 5; i++) op(1, 0, 3'd2, 3'd0, 4'(i), 4'd3, 4'd0, 4'd0, 0);
    chk("sat0", gnt_cnt0, expc(3));
    chk("sat1", gnt_cnt1, 0);
    // random traffic
    for (int i = 0; i < 40; i++)
      op(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 4'($urandom),
         4'($urandom), 4'($urandom), int'($urandom_range(3)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
